// File: rtl/reset_gen_if.sv
// reset_gen_if: board-side signal bundle of the reset generator.
//   btn_n          raw active-low reset button, asynchronous to clk
//   trap           trap indication from the system core
//   power_on_reset registered reset to the system core, active high
//   btn_pressed    debounced button level, 1 = pressed
//   reset_cause    cause of the last reset: 00 power-up/reset input,
//                  01 button, 10 trap, 11 unused
// The slave modport is the reset generator's view; master is the board/core side.
interface reset_gen_if;
    logic       btn_n;
    logic       trap;
    logic       power_on_reset;
    logic       btn_pressed;
    logic [1:0] reset_cause;

    modport master (
        output btn_n,
        output trap,
        input  power_on_reset,
        input  btn_pressed,
        input  reset_cause
    );

    modport slave (
        input  btn_n,
        input  trap,
        output power_on_reset,
        output btn_pressed,
        output reset_cause
    );
endinterface

// File: rtl/reset_gen.sv
// reset_gen: board-level reset generator for the system core.
// Synchronises and debounces the raw reset button, stretches the resulting
// reset, optionally restarts the core a fixed delay after a trap, and records
// what caused the most recent reset.
// Ports:
//   clk    system clock
//   reset  synchronous active-high reset of this block
//   bus    reset_gen_if.slave: btn_n, trap in; power_on_reset, btn_pressed,
//          reset_cause out (all outputs come straight from flops)
// Parameters:
//   DEBOUNCE   stable synchronised samples needed to accept a level change (>= 1)
//   STRETCH    cycles power_on_reset stays high once the button is released (>= 1)
//   TRAPDELAY  cycles from trap to automatic reset; 0 disables trap restart
module reset_gen #(
    parameter int DEBOUNCE  = 20000,
    parameter int STRETCH   = 16,
    parameter int TRAPDELAY = 2000
) (
    input  logic        clk,
    input  logic        reset,
    reset_gen_if.slave  bus
);

    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int SW = $clog2(STRETCH + 1);
    // A zero trap delay would give a zero-width counter; keep one bit so the
    // (unused) counter still elaborates.
    localparam int TW = (TRAPDELAY > 0) ? $clog2(TRAPDELAY + 1) : 1;

    localparam int TD_LAST_I = (TRAPDELAY > 0) ? (TRAPDELAY - 1) : 0;

    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE - 1);
    localparam logic [SW-1:0] ST_LAST = SW'(STRETCH - 1);
    localparam logic [TW-1:0] TD_LAST = TW'(TD_LAST_I);
    localparam logic          TRAP_EN = (TRAPDELAY != 0) ? 1'b1 : 1'b0;

    localparam logic [1:0] CAUSE_POR    = 2'b00;
    localparam logic [1:0] CAUSE_BUTTON = 2'b01;
    localparam logic [1:0] CAUSE_TRAP   = 2'b10;

    typedef enum logic [1:0] {
        ST_ASSERT    = 2'd0,
        ST_RUN       = 2'd1,
        ST_TRAP_WAIT = 2'd2
    } state_e;

    logic          s1_q, s2_q;
    logic          btn_pressed_q, btn_pressed_d;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    state_e        state_q, state_d;
    logic [SW-1:0] stretch_cnt_q, stretch_cnt_d;
    logic [TW-1:0] trap_cnt_q, trap_cnt_d;
    logic          por_q, por_d;
    logic [1:0]    cause_q, cause_d;
    logic          pressed_s;

    // Synchronised button level, 1 = pressed.
    assign pressed_s = ~s2_q;

    // Debouncer: count consecutive samples that disagree with the accepted level.
    always_comb begin
        btn_pressed_d = btn_pressed_q;
        db_cnt_d      = db_cnt_q;
        if (pressed_s != btn_pressed_q) begin
            if (db_cnt_q == DB_LAST) begin
                btn_pressed_d = ~btn_pressed_q;
                db_cnt_d      = '0;
            end else begin
                db_cnt_d = db_cnt_q + DW'(1);
            end
        end else begin
            db_cnt_d = '0;
        end
    end

    // Reset sequencing FSM: next state, counters and cause.
    always_comb begin
        state_d       = state_q;
        stretch_cnt_d = stretch_cnt_q;
        trap_cnt_d    = trap_cnt_q;
        cause_d       = cause_q;
        case (state_q)
            ST_ASSERT: begin
                // Stretch only starts once the button is seen released.
                if (btn_pressed_q) begin
                    stretch_cnt_d = '0;
                end else if (stretch_cnt_q == ST_LAST) begin
                    state_d       = ST_RUN;
                    stretch_cnt_d = '0;
                end else begin
                    stretch_cnt_d = stretch_cnt_q + SW'(1);
                end
            end
            ST_RUN: begin
                // Button wins over a trap raised in the same cycle.
                if (btn_pressed_q) begin
                    state_d       = ST_ASSERT;
                    stretch_cnt_d = '0;
                    cause_d       = CAUSE_BUTTON;
                end else if (bus.trap && TRAP_EN) begin
                    state_d    = ST_TRAP_WAIT;
                    trap_cnt_d = '0;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_TRAP_WAIT: begin
                // Trap falling does not cancel the wait; only the button cuts it short.
                if (btn_pressed_q) begin
                    state_d       = ST_ASSERT;
                    stretch_cnt_d = '0;
                    trap_cnt_d    = '0;
                    cause_d       = CAUSE_BUTTON;
                end else if (trap_cnt_q == TD_LAST) begin
                    state_d       = ST_ASSERT;
                    stretch_cnt_d = '0;
                    trap_cnt_d    = '0;
                    cause_d       = CAUSE_TRAP;
                end else begin
                    trap_cnt_d = trap_cnt_q + TW'(1);
                end
            end
            default: begin
                state_d       = ST_ASSERT;
                stretch_cnt_d = '0;
                trap_cnt_d    = '0;
            end
        endcase
    end

    // power_on_reset is registered from the next state so it tracks state_q exactly.
    always_comb begin
        por_d = (state_d == ST_ASSERT) ? 1'b1 : 1'b0;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q          <= 1'b1;
            s2_q          <= 1'b1;
            btn_pressed_q <= 1'b0;
            db_cnt_q      <= '0;
            state_q       <= ST_ASSERT;
            stretch_cnt_q <= '0;
            trap_cnt_q    <= '0;
            por_q         <= 1'b1;
            cause_q       <= CAUSE_POR;
        end else begin
            s1_q          <= bus.btn_n;
            s2_q          <= s1_q;
            btn_pressed_q <= btn_pressed_d;
            db_cnt_q      <= db_cnt_d;
            state_q       <= state_d;
            stretch_cnt_q <= stretch_cnt_d;
            trap_cnt_q    <= trap_cnt_d;
            por_q         <= por_d;
            cause_q       <= cause_d;
        end
    end

    assign bus.power_on_reset = por_q;
    assign bus.btn_pressed    = btn_pressed_q;
    assign bus.reset_cause    = cause_q;

endmodule

// File: tb/tb_reset_gen.sv
// tb_reset_gen: self-checking bench for reset_gen (DEBOUNCE=4, STRETCH=3,
// TRAPDELAY=5, plus a second instance with TRAPDELAY=0).
// Expected values come from directed per-scenario timing and from a
// window/deadline reference model of the button, stretch and trap rules.
module tb_reset_gen;

    localparam int D    = 4;
    localparam int S    = 3;
    localparam int TD   = 5;
    localparam int MAXE = 4096;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    reset_gen_if bus  ();
    reset_gen_if bus0 ();

    reset_gen #(.DEBOUNCE(D), .STRETCH(S), .TRAPDELAY(TD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    reset_gen #(.DEBOUNCE(D), .STRETCH(S), .TRAPDELAY(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // Reference model state: per-edge histories indexed by edge number.
    int         m_e;
    bit         s1h  [MAXE];   // value the first sync flop holds after edge e
    bit         rsth [MAXE];   // reset high at edge e
    bit         samp [MAXE];   // synchronised "pressed" sample used at edge e
    bit         prh  [MAXE];   // debounced level during the cycle before edge e
    bit         m_pressed;
    int         m_last_tog;
    int         m_mode;        // 0 = reset asserted, 1 = running, 2 = waiting after trap
    int         m_entry;       // edge at which m_mode was entered
    logic [1:0] m_cause;

    // Advance the model by the coming clock edge using the inputs as driven now.
    task automatic model_step();
        int e;
        bit pb, tog, go;
        m_e = m_e + 1;
        e   = m_e;
        if (e >= MAXE) begin
            $display("FAIL model_capacity: edge %0d exceeds history of %0d", e, MAXE);
            $fatal(1);
        end
        rsth[e] = reset;
        s1h[e]  = reset ? 1'b1 : bus.btn_n;
        samp[e] = rsth[e-1] ? 1'b0 : !s1h[e-2];
        pb      = m_pressed;
        prh[e]  = pb;
        if (reset) begin
            m_pressed  = 1'b0;
            m_last_tog = e;
            m_mode     = 0;
            m_entry    = e;
            m_cause    = 2'b00;
        end else begin
            // A level is accepted once the last D samples since the previous
            // change all disagree with the current level.
            tog = 1'b1;
            for (int j = e - D + 1; j <= e; j++)
                if (j <= m_last_tog || samp[j] == pb) tog = 1'b0;
            if (tog) begin
                m_pressed  = !pb;
                m_last_tog = e;
            end
            case (m_mode)
                0: begin
                    // Leave reset once S released cycles have elapsed since entry.
                    go = 1'b1;
                    for (int j = e - S + 1; j <= e; j++)
                        if (j <= m_entry || prh[j]) go = 1'b0;
                    if (go) begin
                        m_mode  = 1;
                        m_entry = e;
                    end
                end
                1: begin
                    if (pb) begin
                        m_mode = 0; m_entry = e; m_cause = 2'b01;
                    end else if (bus.trap && TD != 0) begin
                        m_mode = 2; m_entry = e;
                    end
                end
                default: begin
                    if (pb) begin
                        m_mode = 0; m_entry = e; m_cause = 2'b01;
                    end else if (e == m_entry + TD) begin
                        m_mode = 0; m_entry = e; m_cause = 2'b10;
                    end
                end
            endcase
        end
    endtask

    // One clock: update the model for the edge, then settle on the falling edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [3:0] got, exp, mexp;
        reset = 1'b1;
        tick();
        tick();
        got = {bus.power_on_reset, bus.btn_pressed, bus.reset_cause};
        chk_cnt++;
        if (got !== 4'b1000) $display("FAIL reset_hold: {por,btn,cause} got %b expected %b", got, 4'b1000);
        else pass_cnt++;
        reset = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            exp  = {(i < S) ? 1'b1 : 1'b0, 1'b0, 2'b00};
            got  = {bus.power_on_reset, bus.btn_pressed, bus.reset_cause};
            mexp = {(m_mode == 0), m_pressed, m_cause};
            chk_cnt++;
            if (got !== exp) $display("FAIL reset_release i=%0d: {por,btn,cause} got %b expected %b", i, got, exp);
            else pass_cnt++;
            chk_cnt++;
            if (got !== mexp) $display("FAIL model_reset i=%0d: got %b expected %b", i, got, mexp);
            else pass_cnt++;
            got = {bus0.power_on_reset, bus0.btn_pressed, bus0.reset_cause};
            chk_cnt++;
            if (got !== exp) $display("FAIL reset_release_td0 i=%0d: got %b expected %b", i, got, exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_press();
        logic [3:0] got, exp, mexp;
        bus.btn_n = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            exp  = {(i >= D + 3), (i >= D + 2), (i >= D + 3) ? 2'b01 : 2'b00};
            got  = {bus.power_on_reset, bus.btn_pressed, bus.reset_cause};
            mexp = {(m_mode == 0), m_pressed, m_cause};
            chk_cnt++;
            if (got !== exp) $display("FAIL press_hold i=%0d: {por,btn,cause} got %b expected %b", i, got, exp);
            else pass_cnt++;
            chk_cnt++;
            if (got !== mexp) $display("FAIL model_press i=%0d: got %b expected %b", i, got, mexp);
            else pass_cnt++;
        end
        bus.btn_n = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            exp  = {(i < D + 2 + S), (i < D + 2), 2'b01};
            got  = {bus.power_on_reset, bus.btn_pressed, bus.reset_cause};
            mexp = {(m_mode == 0), m_pressed, m_cause};
            chk_cnt++;
            if (got !== exp) $display("FAIL press_release i=%0d: {por,btn,cause} got %b expected %b", i, got, exp);
            else pass_cnt++;
            chk_cnt++;
            if (got !== mexp) $display("FAIL model_release i=%0d: got %b expected %b", i, got, mexp);
            else pass_cnt++;
        end
    endtask

    task automatic test_glitch();
        logic [3:0] got, mexp;
        for (int i = 1; i <= 14; i++) begin
            bus.btn_n = (i <= D - 1) ? 1'b0 : 1'b1;
            tick();
            got  = {bus.power_on_reset, bus.btn_pressed, bus.reset_cause};
            mexp = {(m_mode == 0), m_pressed, m_cause};
            chk_cnt++;
            if (got[3:2] !== 2'b00) $display("FAIL glitch i=%0d: {por,btn} got %b expected 00", i, got[3:2]);
            else pass_cnt++;
            chk_cnt++;
            if (got !== mexp) $display("FAIL model_glitch i=%0d: got %b expected %b", i, got, mexp);
            else pass_cnt++;
        end
    endtask

    task automatic test_trap();
        logic [3:0] got, exp, mexp;
        for (int i = 1; i <= 12; i++) begin
            bus.trap = (i == 1) ? 1'b1 : 1'b0;
            tick();
            exp  = {(i > TD && i <= TD + S), 1'b0, (i > TD) ? 2'b10 : 2'b01};
            got  = {bus.power_on_reset, bus.btn_pressed, bus.reset_cause};
            mexp = {(m_mode == 0), m_pressed, m_cause};
            chk_cnt++;
            if (got !== exp) $display("FAIL trap_restart i=%0d: {por,btn,cause} got %b expected %b", i, got, exp);
            else pass_cnt++;
            chk_cnt++;
            if (got !== mexp) $display("FAIL model_trap i=%0d: got %b expected %b", i, got, mexp);
            else pass_cnt++;
        end
        bus.trap = 1'b0;
    endtask

    task automatic test_trap_disabled();
        logic [2:0] got;
        bus0.trap = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            got = {bus0.power_on_reset, bus0.reset_cause};
            chk_cnt++;
            if (got !== 3'b000) $display("FAIL trap_disabled i=%0d: {por,cause} got %b expected 000", i, got);
            else pass_cnt++;
        end
        bus0.trap = 1'b0;
    endtask

    task automatic test_press_and_trap();
        logic [3:0] got, exp, mexp;
        bus.btn_n = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            bus.trap = (i == D + 3) ? 1'b1 : 1'b0;
            tick();
            exp  = {(i >= D + 3), (i >= D + 2), (i >= D + 3) ? 2'b01 : 2'b10};
            got  = {bus.power_on_reset, bus.btn_pressed, bus.reset_cause};
            mexp = {(m_mode == 0), m_pressed, m_cause};
            chk_cnt++;
            if (got !== exp) $display("FAIL press_and_trap i=%0d: {por,btn,cause} got %b expected %b", i, got, exp);
            else pass_cnt++;
            chk_cnt++;
            if (got !== mexp) $display("FAIL model_press_trap i=%0d: got %b expected %b", i, got, mexp);
            else pass_cnt++;
        end
        bus.trap  = 1'b0;
        bus.btn_n = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            got  = {bus.power_on_reset, bus.btn_pressed, bus.reset_cause};
            mexp = {(m_mode == 0), m_pressed, m_cause};
            chk_cnt++;
            if (got !== mexp) $display("FAIL model_press_trap_rel i=%0d: got %b expected %b", i, got, mexp);
            else pass_cnt++;
        end
    endtask

    task automatic test_press_in_trapwait();
        logic [3:0] got, exp, mexp;
        bus.btn_n = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            bus.trap = (i == 4) ? 1'b1 : 1'b0;
            tick();
            exp  = {(i >= D + 3), (i >= D + 2), (i >= D + 3) ? 2'b01 : 2'b10};
            got  = {bus.power_on_reset, bus.btn_pressed, bus.reset_cause};
            mexp = {(m_mode == 0), m_pressed, m_cause};
            chk_cnt++;
            if (got !== exp) $display("FAIL press_in_trapwait i=%0d: {por,btn,cause} got %b expected %b", i, got, exp);
            else pass_cnt++;
            chk_cnt++;
            if (got !== mexp) $display("FAIL model_trapwait i=%0d: got %b expected %b", i, got, mexp);
            else pass_cnt++;
        end
        bus.trap  = 1'b0;
        bus.btn_n = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            got  = {bus.power_on_reset, bus.btn_pressed, bus.reset_cause};
            mexp = {(m_mode == 0), m_pressed, m_cause};
            chk_cnt++;
            if (got !== mexp) $display("FAIL model_trapwait_rel i=%0d: got %b expected %b", i, got, mexp);
            else pass_cnt++;
        end
    endtask

    task automatic test_mid_reset();
        logic [3:0] got, exp;
        for (int i = 1; i <= 3; i++) begin
            bus.trap = (i == 1) ? 1'b1 : 1'b0;
            tick();
            got = {bus.power_on_reset, bus.btn_pressed, bus.reset_cause};
            chk_cnt++;
            if (got !== 4'b0001) $display("FAIL mid_reset_wait i=%0d: got %b expected 0001", i, got);
            else pass_cnt++;
        end
        reset = 1'b1;
        tick();
        got = {bus.power_on_reset, bus.btn_pressed, bus.reset_cause};
        chk_cnt++;
        if (got !== 4'b1000) $display("FAIL mid_reset_force: {por,btn,cause} got %b expected 1000", got);
        else pass_cnt++;
        reset = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            // A leftover trap count would fire a trap restart; none may happen here.
            exp = {(i < S), 1'b0, 2'b00};
            got = {bus.power_on_reset, bus.btn_pressed, bus.reset_cause};
            chk_cnt++;
            if (got !== exp) $display("FAIL mid_reset_release i=%0d: got %b expected %b", i, got, exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic [3:0] got, mexp;
        int hold;
        hold = 0;
        for (int i = 1; i <= 900; i++) begin
            if (hold == 0) begin
                bus.btn_n = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
                hold      = $urandom_range(1, 12);
            end
            hold     = hold - 1;
            bus.trap = ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0;
            reset    = ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0;
            tick();
            got  = {bus.power_on_reset, bus.btn_pressed, bus.reset_cause};
            mexp = {(m_mode == 0), m_pressed, m_cause};
            chk_cnt++;
            if (got !== mexp) $display("FAIL model_random i=%0d: got %b expected %b", i, got, mexp);
            else pass_cnt++;
        end
        reset     = 1'b0;
        bus.trap  = 1'b0;
        bus.btn_n = 1'b1;
    endtask

    initial begin
        bus.btn_n  = 1'b1;
        bus.trap   = 1'b0;
        bus0.btn_n = 1'b1;
        bus0.trap  = 1'b0;
        reset      = 1'b1;
        m_e        = 4;
        for (int j = 0; j <= 4; j++) begin
            s1h[j]  = 1'b1;
            rsth[j] = 1'b1;
            samp[j] = 1'b0;
            prh[j]  = 1'b0;
        end
        m_pressed  = 1'b0;
        m_last_tog = 4;
        m_mode     = 0;
        m_entry    = 4;
        m_cause    = 2'b00;
        @(negedge clk);

        test_reset();
        test_press();
        test_glitch();
        test_trap();
        test_press_and_trap();
        test_trap();
        test_press_in_trapwait();
        test_trap_disabled();
        test_mid_reset();
        test_random();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
